// File: rtl/lc3_exec_pkg.sv
// Shared constants for the LC3 execute stage: opcodes, ALU op encoding,
// effective-address offset selects and E_control field positions.
package lc3_exec_pkg;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_AND  = 2'b01,
    ALU_NOT  = 2'b10,
    ALU_RSVD = 2'b11
  } alu_op_e;

  localparam logic [1:0] PCSEL1_OFF11 = 2'b00;
  localparam logic [1:0] PCSEL1_OFF9  = 2'b01;
  localparam logic [1:0] PCSEL1_OFF6  = 2'b10;
  localparam logic [1:0] PCSEL1_ZERO  = 2'b11;

  localparam int EC_ALU_OP_LSB  = 4;
  localparam int EC_PCSEL1_LSB  = 2;
  localparam int EC_PCSEL2_BIT  = 1;
  localparam int EC_OP2SEL_BIT  = 0;

  // Stores read their data register from IR[11:9] instead of IR[2:0].
  function automatic logic is_store(input logic [3:0] opcode);
    return (opcode == OP_ST) || (opcode == OP_STR) || (opcode == OP_STI);
  endfunction

endpackage

// File: rtl/lc3_execute_if.sv
// Decode/regfile-to-execute bundle and execute outputs toward memory/writeback.
// master = upstream/downstream side, slave = the execute stage.
interface lc3_execute_if;
  logic        enable_execute;
  logic [15:0] IR;
  logic [15:0] npc_in;
  logic [5:0]  E_control;
  logic [1:0]  W_control_in;
  logic        mem_control_in;
  logic [15:0] VSR1;
  logic [15:0] VSR2;
  logic        bypass_alu_1;
  logic        bypass_alu_2;
  logic        bypass_mem_1;
  logic        bypass_mem_2;
  logic [15:0] mem_bypass_val;
  logic [2:0]  sr1;
  logic [2:0]  sr2;
  logic [15:0] aluout;
  logic [15:0] pcout;
  logic [15:0] M_data;
  logic [2:0]  dr;
  logic [2:0]  NZP;
  logic [15:0] IR_exec;
  logic [1:0]  W_control_out;
  logic        mem_control_out;

  modport master (
    output enable_execute, IR, npc_in, E_control, W_control_in, mem_control_in,
           VSR1, VSR2, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2,
           mem_bypass_val,
    input  sr1, sr2, aluout, pcout, M_data, dr, NZP, IR_exec, W_control_out,
           mem_control_out
  );

  modport slave (
    input  enable_execute, IR, npc_in, E_control, W_control_in, mem_control_in,
           VSR1, VSR2, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2,
           mem_bypass_val,
    output sr1, sr2, aluout, pcout, M_data, dr, NZP, IR_exec, W_control_out,
           mem_control_out
  );
endinterface

// File: rtl/lc3_exec_alu.sv
// Combinational ALU and effective-address adder for the LC3 execute stage.
module lc3_exec_alu
  import lc3_exec_pkg::*;
(
  input  logic [10:0] ir_i,
  input  logic [15:0] npc_i,
  input  logic [15:0] op1_i,
  input  logic [15:0] op2_i,
  input  alu_op_e     alu_op_i,
  input  logic [1:0]  pcsel1_i,
  input  logic        pcsel2_i,
  input  logic        op2sel_i,
  output logic [15:0] alu_res_o,
  output logic [15:0] addr_o
);

  logic [15:0] op2_eff;
  logic [15:0] offset;
  logic [15:0] base;

  always_comb begin
    op2_eff = op2sel_i ? op2_i : {{11{ir_i[4]}}, ir_i[4:0]};

    alu_res_o = '0;
    case (alu_op_i)
      ALU_ADD: alu_res_o = op1_i + op2_eff;
      ALU_AND: alu_res_o = op1_i & op2_eff;
      ALU_NOT: alu_res_o = ~op1_i;
      default: alu_res_o = '0;
    endcase

    offset = '0;
    case (pcsel1_i)
      PCSEL1_OFF11: offset = {{5{ir_i[10]}}, ir_i[10:0]};
      PCSEL1_OFF9:  offset = {{7{ir_i[8]}},  ir_i[8:0]};
      PCSEL1_OFF6:  offset = {{10{ir_i[5]}}, ir_i[5:0]};
      default:      offset = '0;
    endcase

    base   = pcsel2_i ? npc_i : op1_i;
    addr_o = base + offset;
  end

endmodule

// File: rtl/lc3_execute.sv
// LC3 execute stage: operand muxing and one-cycle pipeline registers.
// Operand forwarding is built only when LC3_EXEC_BYPASS_EN is defined.
module lc3_execute
  import lc3_exec_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  lc3_execute_if.slave ex
);

  logic [3:0]  opcode;
  logic [15:0] op1, op2;
  logic [15:0] alu_res, addr;

  logic [15:0] aluout_q, aluout_d;
  logic [15:0] pcout_q, pcout_d;
  logic [15:0] m_data_q, m_data_d;
  logic [2:0]  dr_q, dr_d;
  logic [2:0]  nzp_q, nzp_d;
  logic [15:0] ir_q, ir_d;
  logic [1:0]  wctl_q, wctl_d;
  logic        mctl_q, mctl_d;

  assign opcode = ex.IR[15:12];
  assign ex.sr1 = ex.IR[8:6];
  assign ex.sr2 = is_store(opcode) ? ex.IR[11:9] : ex.IR[2:0];

  // Forwarding from aluout_q picks up the previous instruction's result.
  always_comb begin
    op1 = ex.VSR1;
    op2 = ex.VSR2;
`ifdef LC3_EXEC_BYPASS_EN
    if (ex.bypass_alu_1)      op1 = aluout_q;
    else if (ex.bypass_mem_1) op1 = ex.mem_bypass_val;
    if (ex.bypass_alu_2)      op2 = aluout_q;
    else if (ex.bypass_mem_2) op2 = ex.mem_bypass_val;
`endif
  end

  lc3_exec_alu u_alu (
    .ir_i      (ex.IR[10:0]),
    .npc_i     (ex.npc_in),
    .op1_i     (op1),
    .op2_i     (op2),
    .alu_op_i  (alu_op_e'(ex.E_control[EC_ALU_OP_LSB +: 2])),
    .pcsel1_i  (ex.E_control[EC_PCSEL1_LSB +: 2]),
    .pcsel2_i  (ex.E_control[EC_PCSEL2_BIT]),
    .op2sel_i  (ex.E_control[EC_OP2SEL_BIT]),
    .alu_res_o (alu_res),
    .addr_o    (addr)
  );

  always_comb begin
    aluout_d = (opcode == OP_LEA) ? addr : alu_res;
    pcout_d  = addr;
    m_data_d = op2;
    dr_d     = ex.IR[11:9];
    nzp_d    = 3'b000;
    if (opcode == OP_BR)       nzp_d = ex.IR[11:9];
    else if (opcode == OP_JMP) nzp_d = 3'b111;
    ir_d     = ex.IR;
    wctl_d   = ex.W_control_in;
    mctl_d   = ex.mem_control_in;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      aluout_q <= '0;
      pcout_q  <= '0;
      m_data_q <= '0;
      dr_q     <= '0;
      nzp_q    <= '0;
      ir_q     <= '0;
      wctl_q   <= '0;
      mctl_q   <= 1'b0;
    end else if (ex.enable_execute) begin
      aluout_q <= aluout_d;
      pcout_q  <= pcout_d;
      m_data_q <= m_data_d;
      dr_q     <= dr_d;
      nzp_q    <= nzp_d;
      ir_q     <= ir_d;
      wctl_q   <= wctl_d;
      mctl_q   <= mctl_d;
    end
  end

  assign ex.aluout          = aluout_q;
  assign ex.pcout           = pcout_q;
  assign ex.M_data          = m_data_q;
  assign ex.dr              = dr_q;
  assign ex.NZP             = nzp_q;
  assign ex.IR_exec         = ir_q;
  assign ex.W_control_out   = wctl_q;
  assign ex.mem_control_out = mctl_q;

endmodule

// File: tb/tb_lc3_execute.sv
// Self-checking bench for lc3_execute: an instruction-level reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_lc3_execute;

  logic clock = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  lc3_execute_if bus ();

  lc3_execute dut (
    .clock (clock),
    .reset (reset),
    .ex    (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sx(input int v, input int bits);
    return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
  endfunction

  // Reference model: what the stage must hold after each clock edge.
  logic        mv = 1'b0;
  logic [15:0] e_alu, e_pc, e_md, e_ir;
  logic [2:0]  e_dr, e_nzp;
  logic [1:0]  e_wc;
  logic        e_mc;

  always @(posedge clock) begin : model
    int o1, o2, b2, r, base, off, addr, opc, aop, p1;
    if (reset) begin
      e_alu = 0; e_pc = 0; e_md = 0; e_ir = 0;
      e_dr = 0; e_nzp = 0; e_wc = 0; e_mc = 0;
      mv = 1'b1;
    end else if (bus.enable_execute) begin
      o1 = int'(bus.VSR1);
      o2 = int'(bus.VSR2);
`ifdef LC3_EXEC_BYPASS_EN
      if (bus.bypass_alu_1)      o1 = int'(e_alu);
      else if (bus.bypass_mem_1) o1 = int'(bus.mem_bypass_val);
      if (bus.bypass_alu_2)      o2 = int'(e_alu);
      else if (bus.bypass_mem_2) o2 = int'(bus.mem_bypass_val);
`endif
      aop = int'(bus.E_control[5:4]);
      p1  = int'(bus.E_control[3:2]);
      opc = int'(bus.IR[15:12]);
      b2  = bus.E_control[0] ? o2 : (sx(int'(bus.IR[4:0]), 5) & 'hFFFF);
      case (aop)
        0:       r = (o1 + b2) & 'hFFFF;
        1:       r = o1 & b2;
        2:       r = (~o1) & 'hFFFF;
        default: r = 0;
      endcase
      base = bus.E_control[1] ? int'(bus.npc_in) : o1;
      case (p1)
        0:       off = sx(int'(bus.IR[10:0]), 11);
        1:       off = sx(int'(bus.IR[8:0]), 9);
        2:       off = sx(int'(bus.IR[5:0]), 6);
        default: off = 0;
      endcase
      addr  = (base + off) & 'hFFFF;
      e_alu = 16'((opc == 14) ? addr : r);
      e_pc  = 16'(addr);
      e_md  = 16'(o2);
      e_dr  = bus.IR[11:9];
      e_nzp = (opc == 0) ? bus.IR[11:9] : ((opc == 12) ? 3'b111 : 3'b000);
      e_ir  = bus.IR;
      e_wc  = bus.W_control_in;
      e_mc  = bus.mem_control_in;
    end
  end

  always @(negedge clock) begin : compare
    logic [2:0] esr2;
    if (mv) begin
      chk("aluout", bus.aluout, e_alu);
      chk("pcout", bus.pcout, e_pc);
      chk("M_data", bus.M_data, e_md);
      chk("dr", {13'b0, bus.dr}, {13'b0, e_dr});
      chk("NZP", {13'b0, bus.NZP}, {13'b0, e_nzp});
      chk("IR_exec", bus.IR_exec, e_ir);
      chk("W_control_out", {14'b0, bus.W_control_out}, {14'b0, e_wc});
      chk("mem_control_out", {15'b0, bus.mem_control_out}, {15'b0, e_mc});
      esr2 = (bus.IR[15:12] == 4'd3 || bus.IR[15:12] == 4'd7 || bus.IR[15:12] == 4'd11)
             ? bus.IR[11:9] : bus.IR[2:0];
      chk("sr1", {13'b0, bus.sr1}, {13'b0, bus.IR[8:6]});
      chk("sr2", {13'b0, bus.sr2}, {13'b0, esr2});
    end
  end

  task automatic apply(input logic [15:0] ir, input logic [5:0] ec, input logic [15:0] npc,
                       input logic [15:0] v1, input logic [15:0] v2);
    bus.IR             = ir;
    bus.E_control      = ec;
    bus.npc_in         = npc;
    bus.VSR1           = v1;
    bus.VSR2           = v2;
    bus.W_control_in   = ir[1:0];
    bus.mem_control_in = ir[3];
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset              = 1'b1;
    bus.enable_execute = 1'b1;
    bus.bypass_alu_1   = 1'b0;
    bus.bypass_alu_2   = 1'b0;
    bus.bypass_mem_1   = 1'b0;
    bus.bypass_mem_2   = 1'b0;
    bus.mem_bypass_val = 16'h0000;
    apply(16'h1642, 6'b000001, 16'h3000, 16'h0005, 16'h0003);
    apply(16'h1642, 6'b000001, 16'h3000, 16'h0005, 16'h0003);
    chk("lit_reset_aluout", bus.aluout, 16'h0000);
    chk("lit_reset_nzp", {13'b0, bus.NZP}, 16'h0000);
    reset = 1'b0;

    // ADD R3,R1,R2
    apply(16'h1642, 6'b000001, 16'h3000, 16'h0005, 16'h0003);
    chk("lit_add_aluout", bus.aluout, 16'h0008);
    chk("lit_add_dr", {13'b0, bus.dr}, 16'h0003);
    chk("lit_add_nzp", {13'b0, bus.NZP}, 16'h0000);

    // ADD imm 1 with both op1 forwards asserted: ALU path wins
    bus.bypass_alu_1   = 1'b1;
    bus.bypass_mem_1   = 1'b1;
    bus.mem_bypass_val = 16'h1234;
    apply(16'h1661, 6'b000000, 16'h3000, 16'h0100, 16'h0000);
`ifdef LC3_EXEC_BYPASS_EN
    chk("lit_fwd_alu", bus.aluout, 16'h0009);
`else
    chk("lit_fwd_alu", bus.aluout, 16'h0101);
`endif
    bus.bypass_alu_1 = 1'b0;
    bus.bypass_mem_1 = 1'b0;

    // op2 forwarded from memory stage
    bus.bypass_mem_2 = 1'b1;
    apply(16'h1642, 6'b000001, 16'h3000, 16'h0001, 16'h0003);
`ifdef LC3_EXEC_BYPASS_EN
    chk("lit_fwd_mem", bus.aluout, 16'h1235);
    chk("lit_fwd_mdata", bus.M_data, 16'h1234);
`else
    chk("lit_fwd_mem", bus.aluout, 16'h0004);
    chk("lit_fwd_mdata", bus.M_data, 16'h0003);
`endif
    bus.bypass_mem_2 = 1'b0;

    apply(16'h5262, 6'b010000, 16'h3000, 16'h00FF, 16'h0000);
    chk("lit_and_imm", bus.aluout, 16'h0002);
    apply(16'h9A7F, 6'b100000, 16'h3000, 16'h0F0F, 16'h0000);
    chk("lit_not", bus.aluout, 16'hF0F0);
    apply(16'h0DFE, 6'b000110, 16'h3005, 16'h0000, 16'h0000);
    chk("lit_br_pcout", bus.pcout, 16'h3003);
    chk("lit_br_nzp", {13'b0, bus.NZP}, 16'h0006);
    apply(16'h3805, 6'b000110, 16'h3000, 16'h0000, 16'hBEEF);
    chk("lit_st_sr2", {13'b0, bus.sr2}, 16'h0004);
    chk("lit_st_mdata", bus.M_data, 16'hBEEF);
    chk("lit_st_pcout", bus.pcout, 16'h3005);
    apply(16'hC1C0, 6'b001000, 16'h3000, 16'h4000, 16'h0000);
    chk("lit_jmp_pcout", bus.pcout, 16'h4000);
    chk("lit_jmp_nzp", {13'b0, bus.NZP}, 16'h0007);
    apply(16'hE5FF, 6'b000110, 16'h3010, 16'h0000, 16'h0000);
    chk("lit_lea_aluout", bus.aluout, 16'h300F);
    apply(16'h27FF, 6'b000010, 16'h3000, 16'h0000, 16'h0000);
    chk("lit_off11", bus.pcout, 16'h2FFF);
    apply(16'h6440, 6'b001100, 16'h3000, 16'h1234, 16'h0000);
    chk("lit_off_zero", bus.pcout, 16'h1234);
    apply(16'h1642, 6'b110001, 16'h3000, 16'h0005, 16'h0003);
    chk("lit_alu_rsvd", bus.aluout, 16'h0000);
    apply(16'h1642, 6'b000001, 16'h3000, 16'hFFFF, 16'h0002);
    chk("lit_add_wrap", bus.aluout, 16'h0001);

    // Hold for three cycles while IR changes
    bus.enable_execute = 1'b0;
    apply(16'h5262, 6'b010000, 16'h4000, 16'h00FF, 16'h0000);
    apply(16'h0DFE, 6'b000110, 16'h3005, 16'h0000, 16'h0000);
    apply(16'h1FC0, 6'b000000, 16'h3000, 16'h0007, 16'h0000);
    chk("lit_hold_aluout", bus.aluout, 16'h0001);
    chk("lit_hold_ir", bus.IR_exec, 16'h1642);
    chk("lit_hold_sr1", {13'b0, bus.sr1}, 16'h0007);

    // Reset beats enable and discards the in-flight instruction
    bus.enable_execute = 1'b1;
    reset = 1'b1;
    apply(16'h1642, 6'b000001, 16'h3000, 16'h0005, 16'h0003);
    chk("lit_rst_aluout", bus.aluout, 16'h0000);
    chk("lit_rst_dr", {13'b0, bus.dr}, 16'h0000);
    chk("lit_rst_ir", bus.IR_exec, 16'h0000);
    reset = 1'b0;
    apply(16'h1642, 6'b000001, 16'h3000, 16'h0005, 16'h0003);
    chk("lit_after_rst", bus.aluout, 16'h0008);

    @(negedge clock);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
